// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO with storage, occupancy count,
//               programmable almost-full / almost-empty thresholds, sticky
//               overflow / underflow flags and a read port.
//               Optional build macro FIFO_FWFT_EN selects first-word-fall-
//               through reads. When the macro is absent, reads are
//               registered and have one cycle of latency.
// Ports       : clk, rst_n (async active-low)
//               wr_en / wr_data                   write request and word
//               rd_en / rd_data / rd_valid        read request and output
//               full, empty, almost_full, almost_empty, count
//                                                 occupancy status
//               clr_err, overflow, underflow      sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_TH   = 14,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH       = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AFULL_TH  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AEMPTY_TH = AEMPTY_TH[ADDR_WIDTH:0];

    // Elaboration-time sanity checks on threshold parameters
    generate
        if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
            $error("sync_fifo_ctrl: AFULL_TH must be in 1..DEPTH");
        end
        if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
            $error("sync_fifo_ctrl: AEMPTY_TH must be in 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ovf_evt;
    logic w_udf_evt;

    // Status comes only from the registered count, so there is no
    // combinational path from the request inputs to the flags.
    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);

    assign w_wr_acc  = wr_en & ~w_full;
    assign w_rd_acc  = rd_en & ~w_empty;
    assign w_ovf_evt = wr_en &  w_full;
    assign w_udf_evt = rd_en &  w_empty;

    // Storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
                r_wr_ptr                        <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy. It is unchanged when both or neither side is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors. A new event wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~clr_err) | w_ovf_evt;
            r_underflow <= (r_underflow & ~clr_err) | w_udf_evt;
        end
    end

`ifdef FIFO_FWFT_EN
    // The head word is presented directly. rd_en only pops it.
    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign rd_valid = ~w_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL_TH);
    assign almost_empty = (r_count <= c_AEMPTY_TH);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
